booth_seq_mult: RTL and testbench

- Sequential radix-2 Booth multiplier controller: signed WIDTH x WIDTH operands, signed 2*WIDTH product.
- Sits directly upstream of the 2*WIDTH-bit ripple adder stage. Each cycle it drives that adder's a/b operands and captures the adder's sum back into its accumulator.
- Adds one Booth partial product per cycle under a start/busy/done handshake.

---
 rtl/booth_pkg.sv | 31 +++
 rtl/booth_pp_sel.sv | 27 ++
 rtl/booth_seq_mult.sv | 159 +++++++++++++++
 tb/tb_booth_seq_mult.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package booth_pkg;

    localparam int unsigned BOOTH_WIDTH = 7;
    localparam int unsigned PW          = 2 * BOOTH_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ITER,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        PP_ZERO,
        PP_ADD,
        PP_SUB
    } pp_op_e;

    // Radix-2 Booth recoding of {Q[i], Q[i-1]}.
    function automatic pp_op_e booth_encode(input logic [1:0] pair);
        pp_op_e op;
        case (pair)
            2'b01:   op = PP_ADD;
            2'b10:   op = PP_SUB;
            default: op = PP_ZERO;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_pp_sel.sv
// Selects the shifted Booth partial product (0, +M<<i or -M<<i) for one step.
module booth_pp_sel
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = BOOTH_WIDTH,
    parameter int unsigned IDX_W = 3
) (
    input  logic [1:0]           q_pair,
    input  logic [2*WIDTH-1:0]   pos_m,
    input  logic [2*WIDTH-1:0]   neg_m,
    input  logic [IDX_W-1:0]     idx,
    output logic [2*WIDTH-1:0]   add_b_c
);

    pp_op_e op;

    always_comb begin
        op      = booth_encode(q_pair);
        add_b_c = '0;
        case (op)
            PP_ADD:  add_b_c = pos_m << idx;
            PP_SUB:  add_b_c = neg_m << idx;
            default: add_b_c = '0;
        endcase
    end

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier controller; one partial product per cycle
// through an external 2*WIDTH-bit adder whose sum is captured into the accumulator.
module booth_seq_mult
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = BOOTH_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   add_a,
    output logic [2*WIDTH-1:0]   add_b,
    input  logic [2*WIDTH-1:0]   add_sum,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam int unsigned IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_e              state_q,   state_d;
    logic [WIDTH-1:0]    m_q,       m_d;
    logic [WIDTH-1:0]    q_q,       q_d;
    logic [PROD_W-1:0]   pos_m_q,   pos_m_d;
    logic [PROD_W-1:0]   neg_m_q,   neg_m_d;
    logic                q_prev_q,  q_prev_d;
    logic [IDX_W-1:0]    idx_q,     idx_d;
    logic [PROD_W-1:0]   acc_q,     acc_d;
    logic [PROD_W-1:0]   add_b_q,   add_b_d;
    logic                busy_q,    busy_d;
    logic                done_q,    done_d;
    logic [PROD_W-1:0]   product_q, product_d;

    logic [1:0]          next_pair;
    logic [PROD_W-1:0]   next_pp;

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        q_d       = q_q;
        pos_m_d   = pos_m_q;
        neg_m_d   = neg_m_q;
        q_prev_d  = q_prev_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        product_d = product_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = multiplicand;
                    q_d     = multiplier;
                    state_d = LOAD;
                    busy_d  = 1'b1;
                end
            end
            LOAD: begin
                acc_d    = '0;
                pos_m_d  = {{WIDTH{m_q[WIDTH-1]}}, m_q};
                neg_m_d  = ~pos_m_d + PROD_W'(1);
                q_prev_d = 1'b0;
                idx_d    = '0;
                state_d  = ITER;
                busy_d   = 1'b1;
            end
            ITER: begin
                acc_d = add_sum;
                if (idx_q == LAST_IDX) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    product_d = add_sum;
                end else begin
                    idx_d  = idx_q + IDX_W'(1);
                    busy_d = 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    m_d     = multiplicand;
                    q_d     = multiplier;
                    state_d = LOAD;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bit pair for the step that the next cycle will execute.
    always_comb begin
        next_pair[1] = q_d[idx_d];
        next_pair[0] = (idx_d == '0) ? q_prev_d : q_d[idx_d - IDX_W'(1)];
    end

    booth_pp_sel #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_pp_sel (
        .q_pair  (next_pair),
        .pos_m   (pos_m_d),
        .neg_m   (neg_m_d),
        .idx     (idx_d),
        .add_b_c (next_pp)
    );

    // add_b is registered one cycle ahead so it lines up with acc in ITER.
    always_comb begin
        add_b_d = '0;
        if (state_d == ITER) begin
            add_b_d = next_pp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            m_q       <= '0;
            q_q       <= '0;
            pos_m_q   <= '0;
            neg_m_q   <= '0;
            q_prev_q  <= 1'b0;
            idx_q     <= '0;
            acc_q     <= '0;
            add_b_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            q_q       <= q_d;
            pos_m_q   <= pos_m_d;
            neg_m_q   <= neg_m_d;
            q_prev_q  <= q_prev_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            add_b_q   <= add_b_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign add_a   = acc_q;
    assign add_b   = add_b_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed bench for booth_seq_mult with the external ripple adder modelled inline.
module tb_booth_seq_mult;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [6:0]  multiplicand;
    logic [6:0]  multiplier;
    logic [13:0] add_a;
    logic [13:0] add_b;
    logic [13:0] add_sum;
    logic        busy;
    logic        done;
    logic [13:0] product;

    int n_checks;
    int n_errors;

    booth_seq_mult #(.WIDTH(7)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_sum      (add_sum),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    assign add_sum = add_a + add_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Start at the current negedge and follow the operation to its done pulse.
    task automatic do_mult(input string tag, input logic [6:0] m, input logic [6:0] q,
                           input logic [13:0] exp_b0, input logic [13:0] exp_p);
        int lat;
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        check_eq({tag, "_busy_load"}, 32'(busy), 32'd1);
        while (!done && lat < 30) begin
            @(negedge clk);
            lat++;
            if (lat == 2) check_eq({tag, "_add_b_i0"}, 32'(add_b), 32'(exp_b0));
            if (lat == 8) check_eq({tag, "_busy_last"}, 32'(busy), 32'd1);
        end
        check_eq({tag, "_latency"}, 32'(lat), 32'd9);
        check_eq({tag, "_product"}, 32'(product), 32'(exp_p));
        check_eq({tag, "_busy_done"}, 32'(busy), 32'd0);
        check_eq({tag, "_add_b_done"}, 32'(add_b), 32'd0);
        check_eq({tag, "_add_a_done"}, 32'(add_a), 32'(exp_p));
    endtask

    initial begin
        int lat;
        int n_done;
        int first_lat;
        logic [13:0] got_p;

        n_checks     = 0;
        n_errors     = 0;
        rst_n        = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_product", 32'(product), 32'd0);
        check_eq("rst_add_a", 32'(add_a), 32'd0);
        check_eq("rst_add_b", 32'(add_b), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_mult("m3_q5", 7'h03, 7'h05, 14'h3FFD, 14'h000F);
        @(negedge clk);
        check_eq("idle_done_low", 32'(done), 32'd0);
        do_mult("mn3_q5", 7'h7D, 7'h05, 14'h0003, 14'h3FF1);
        @(negedge clk);
        do_mult("mn64_qn64", 7'h40, 7'h40, 14'h0000, 14'h1000);
        @(negedge clk);

        // Second call starts during the DONE cycle of the first.
        do_mult("m0_qn1", 7'h00, 7'h7F, 14'h0000, 14'h0000);
        do_mult("mn1_qn1", 7'h7F, 7'h7F, 14'h0001, 14'h0001);
        @(negedge clk);

        // Start pulses while busy must be ignored.
        multiplicand = 7'h03;
        multiplier   = 7'h05;
        start        = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        lat       = 1;
        n_done    = 0;
        first_lat = 0;
        got_p     = '0;
        for (int k = 0; k < 24; k++) begin
            if (lat == 3 || lat == 5) begin
                start        = 1'b1;
                multiplicand = 7'h07;
                multiplier   = 7'h07;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
            if (done) begin
                n_done++;
                if (first_lat == 0) begin
                    first_lat = lat;
                    got_p     = product;
                end
            end
        end
        start = 1'b0;
        check_eq("ign_done_count", 32'(n_done), 32'd1);
        check_eq("ign_latency", 32'(first_lat), 32'd9);
        check_eq("ign_product", 32'(got_p), 32'h000F);
        check_eq("ign_product_hold", 32'(product), 32'h000F);

        // Reset asserted mid-ITER aborts the operation.
        multiplicand = 7'h05;
        multiplier   = 7'h05;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_product", 32'(product), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        n_done = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check_eq("abort_no_done", 32'(n_done), 32'd0);
        check_eq("abort_idle_busy", 32'(busy), 32'd0);
        check_eq("abort_product_idle", 32'(product), 32'd0);

        do_mult("m2_q3", 7'h02, 7'h03, 14'h3FFE, 14'h0006);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
